cart_mem_arbiter: RTL and testbench
===================================

Name: cart_mem_arbiter

Overview:
Shares the single SDRAM command port between two requesters: the ROM download stream (byte writes from data_io) and console cartridge reads. Download bytes are buffered in a small FIFO. Reads carry a one-entry address cache. The block sits between data_io / the console core and the sdram controller, replacing the ad-hoc address/rd/we muxing in the top level.

Parameters:
ADDR_W, 25, address width for both requesters and the memory port.
FIFO_DEPTH, 4, download write FIFO entries; power of 2, minimum 2.
MEM_CYCLES, 4, cycles one SDRAM command occupies the port. Read data is valid on mem_dout at the end of the last of these cycles. Minimum 2.

Ports:
clk_sys  in  1  system clock (24 MHz)
reset  in  1  asynchronous, active-high reset
dl_active  in  1  download in progress (ioctl_download)
dl_wr  in  1  one-cycle byte write strobe
dl_addr  in  ADDR_W  write byte address
dl_data  in  8  write byte
dl_full  out  1  FIFO full
dl_overflow  out  1  sticky: a dl_wr arrived while the FIFO was full
cart_rd  in  1  one-cycle read request
cart_addr  in  ADDR_W  read address
cart_dout  out  8  read data
cart_valid  out  1  one-cycle pulse; cart_dout is valid in the same cycle
mem_addr  out  ADDR_W  sdram address
mem_din  out  16  sdram write data
mem_rd  out  1  sdram read command, one cycle
mem_we  out  1  sdram write command, one cycle
mem_dout  in  16  sdram read data
busy  out  1  state machine not in IDLE, or FIFO not empty

Behaviour:
- Reset (async): all of the following are 0 or cleared:
  - outputs: dl_full, dl_overflow, cart_dout, cart_valid, mem_addr, mem_din, mem_rd, mem_we, busy
  - FIFO emptied, cache invalid, pending read cleared, state = IDLE.
- Reset asserted mid-command aborts the command; no cart_valid is produced for it.
- FIFO:
  - Push on dl_wr & !dl_full.
  - dl_wr while full: byte dropped, dl_overflow set.
  - dl_overflow clears only on reset or on a rising edge of dl_active.
  - Simultaneous push and pop in one cycle is legal, including when full.
- Pending read register:
  - cart_rd latches cart_addr and sets pending.
  - A new cart_rd while a request is pending but not yet issued overwrites the address; only the newest request is answered.
  - cart_rd while a read is in flight latches a pending request, served after the current one completes.
- Cache hit: cart_rd with cache valid and cart_addr == cached address produces no SDRAM access. cart_valid and cart_dout are asserted the next cycle, with no pending request recorded.
- State machine: IDLE, CMD, WAIT.
  - IDLE, FIFO not empty: pop the head entry and enter CMD (write).
  - IDLE, FIFO empty, pending read, dl_active = 0: enter CMD (read).
  - Reads never issue while dl_active = 1 or the FIFO is non-empty. Writes have strict priority.
  - CMD (write), one cycle: mem_we = 1, mem_addr = entry address, mem_din = {byte, byte}. Cache invalidated.
  - CMD (read), one cycle: mem_rd = 1, mem_addr = pending address; pending cleared.
  - WAIT: MEM_CYCLES-1 cycles with mem_rd = mem_we = 0; mem_addr is held for the whole command.
  - On the final WAIT edge of a read: cart_dout <= mem_dout[7:0], cache <= {address, data}, valid, and cart_valid pulses in the following cycle.
  - WAIT -> IDLE.
- Latency:
  - Read miss from IDLE: cart_rd in cycle 0, mem_rd in cycle 1, cart_valid in cycle MEM_CYCLES+1.
  - Write: throughput one byte per MEM_CYCLES+1 cycles.
- mem_rd and mem_we are never high together and are never high in consecutive cycles.
- busy = (state != IDLE) | FIFO non-empty, registered.

Test Plan:
- Reset released, MEM_CYCLES = 4; cart_rd at 0x0100 with mem_dout returning 0x00A5 -> mem_rd in cycle 1, addr 0x0100; cart_valid with cart_dout = 0xA5 in cycle 5.
- Repeat cart_rd at 0x0100 -> cart_valid next cycle, data 0xA5, no mem_rd. Then cart_rd at 0x0101 -> a new SDRAM read is issued.
- dl_active = 1, 6 back-to-back dl_wr (addr 0..5, data 0x10..0x15), FIFO_DEPTH = 4 -> dl_full asserts; dl_overflow = 1; the writes that are issued carry mem_din = 0x1010, 0x1111, …; a write to a cached address clears cache.
- cart_rd during dl_active = 1 -> no mem_rd until dl_active = 0 and FIFO empty, then exactly one read is issued.
- Two cart_rd (0x20 then 0x30) before issue -> only 0x30 is read, and a single cart_valid results.
- Assert reset during WAIT of a read -> all outputs 0 immediately, no cart_valid afterwards, busy = 0.

Source files
------------

// File: rtl/cart_mem_arbiter.sv
`default_nettype none
// ==========================================================================
// cart_mem_arbiter: shares one SDRAM command port between buffered download
// byte writes (strict priority) and cartridge reads with a one-entry cache.
// Revision: 1.0
// ==========================================================================
module cart_mem_arbiter #(
    parameter int ADDR_W     = 25,
    parameter int FIFO_DEPTH = 4,
    parameter int MEM_CYCLES = 4
) (
    input  logic              clk_sys_i,
    input  logic              reset_i,
    input  logic              dl_active_i,
    input  logic              dl_wr_i,
    input  logic [ADDR_W-1:0] dl_addr_i,
    input  logic [7:0]        dl_data_i,
    output logic              dl_full_o,
    output logic              dl_overflow_o,
    input  logic              cart_rd_i,
    input  logic [ADDR_W-1:0] cart_addr_i,
    output logic [7:0]        cart_dout_o,
    output logic              cart_valid_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [15:0]       mem_din_o,
    output logic              mem_rd_o,
    output logic              mem_we_o,
    input  logic [15:0]       mem_dout_i,
    output logic              busy_o
);

    localparam int c_PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int c_WCNT_W = $clog2(MEM_CYCLES);

    localparam logic [c_PTR_W:0]    c_FULL     = (c_PTR_W+1)'(FIFO_DEPTH);
    localparam logic [c_PTR_W:0]    c_CNT_ONE  = (c_PTR_W+1)'(1);
    localparam logic [c_PTR_W-1:0]  c_PTR_ONE  = c_PTR_W'(1);
    localparam logic [c_WCNT_W-1:0] c_WAIT_END = c_WCNT_W'(MEM_CYCLES-2);
    localparam logic [c_WCNT_W-1:0] c_WAIT_ONE = c_WCNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CMD  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                is_rd_q, is_rd_d;
    logic [c_WCNT_W-1:0] wcnt_q, wcnt_d;

    logic [ADDR_W-1:0]   fifo_addr_q [FIFO_DEPTH];
    logic [7:0]          fifo_data_q [FIFO_DEPTH];
    logic [c_PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [c_PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [c_PTR_W:0]    count_q, count_d;

    logic                ovf_q, ovf_d;
    logic                dl_active_q;

    logic                pend_q, pend_d;
    logic [ADDR_W-1:0]   pend_addr_q, pend_addr_d;

    logic                cache_valid_q, cache_valid_d;
    logic [ADDR_W-1:0]   cache_addr_q, cache_addr_d;
    logic [7:0]          cache_data_q, cache_data_d;

    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [15:0]         mem_din_q, mem_din_d;
    logic                mem_rd_q, mem_rd_d;
    logic                mem_we_q, mem_we_d;
    logic [7:0]          cart_dout_q, cart_dout_d;
    logic                cart_valid_q, cart_valid_d;
    logic                busy_q, busy_d;

    logic                w_full;
    logic                w_push;
    logic                w_pop;
    logic                w_rd_done;
    logic                w_hit;
    logic                w_miss;
    logic                w_rd_issue;
    logic [ADDR_W-1:0]   w_req_addr;
    logic                w_unused;

    assign w_unused   = ^mem_dout_i[15:8];

    assign w_full     = (count_q == c_FULL);
    assign w_push     = dl_wr_i & ~w_full;
    assign w_pop      = (state_q == S_IDLE) & (count_q != '0);
    assign w_rd_done  = (state_q == S_WAIT) & (wcnt_q == c_WAIT_END) & is_rd_q;
    // A hit coinciding with a read completion is treated as a miss so the
    // cache and cart_dout are never updated from two sources in one edge.
    assign w_hit      = cart_rd_i & cache_valid_q & (cart_addr_i == cache_addr_q) & ~w_rd_done;
    assign w_miss     = cart_rd_i & ~w_hit;
    // A fresh miss in IDLE is issued directly, keeping miss latency minimal.
    assign w_req_addr = w_miss ? cart_addr_i : pend_addr_q;
    assign w_rd_issue = (state_q == S_IDLE) & (count_q == '0) & ~dl_active_i & (pend_q | w_miss);

    always_comb begin
        state_d       = state_q;
        is_rd_d       = is_rd_q;
        wcnt_d        = wcnt_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        ovf_d         = ovf_q;
        pend_d        = pend_q;
        pend_addr_d   = pend_addr_q;
        cache_valid_d = cache_valid_q;
        cache_addr_d  = cache_addr_q;
        cache_data_d  = cache_data_q;
        mem_addr_d    = mem_addr_q;
        mem_din_d     = mem_din_q;
        mem_rd_d      = 1'b0;
        mem_we_d      = 1'b0;
        cart_dout_d   = cart_dout_q;
        cart_valid_d  = 1'b0;

        if (w_push) begin
            wr_ptr_d = wr_ptr_q + c_PTR_ONE;
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + c_PTR_ONE;
        end
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + c_CNT_ONE;
            2'b01:   count_d = count_q - c_CNT_ONE;
            default: count_d = count_q;
        endcase

        if (dl_active_i & ~dl_active_q) begin
            ovf_d = 1'b0;
        end
        if (dl_wr_i & w_full) begin
            ovf_d = 1'b1;
        end

        if (w_rd_issue) begin
            pend_d = 1'b0;
        end else if (w_miss) begin
            pend_d      = 1'b1;
            pend_addr_d = cart_addr_i;
        end

        if (w_hit) begin
            cart_valid_d = 1'b1;
            cart_dout_d  = cache_data_q;
        end

        case (state_q)
            S_IDLE: begin
                if (w_pop) begin
                    state_d       = S_CMD;
                    is_rd_d       = 1'b0;
                    mem_we_d      = 1'b1;
                    mem_addr_d    = fifo_addr_q[rd_ptr_q];
                    mem_din_d     = {fifo_data_q[rd_ptr_q], fifo_data_q[rd_ptr_q]};
                    cache_valid_d = 1'b0;
                end else if (w_rd_issue) begin
                    state_d    = S_CMD;
                    is_rd_d    = 1'b1;
                    mem_rd_d   = 1'b1;
                    mem_addr_d = w_req_addr;
                end
            end
            S_CMD: begin
                state_d = S_WAIT;
                wcnt_d  = '0;
            end
            S_WAIT: begin
                if (wcnt_q == c_WAIT_END) begin
                    state_d = S_IDLE;
                    if (is_rd_q) begin
                        cart_dout_d   = mem_dout_i[7:0];
                        cart_valid_d  = 1'b1;
                        cache_valid_d = 1'b1;
                        cache_addr_d  = mem_addr_q;
                        cache_data_d  = mem_dout_i[7:0];
                    end
                end else begin
                    wcnt_d = wcnt_q + c_WAIT_ONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE) | (count_d != '0);
    end

    always_ff @(posedge clk_sys_i or posedge reset_i) begin
        if (reset_i) begin
            state_q       <= S_IDLE;
            is_rd_q       <= 1'b0;
            wcnt_q        <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            ovf_q         <= 1'b0;
            dl_active_q   <= 1'b0;
            pend_q        <= 1'b0;
            pend_addr_q   <= '0;
            cache_valid_q <= 1'b0;
            cache_addr_q  <= '0;
            cache_data_q  <= '0;
            mem_addr_q    <= '0;
            mem_din_q     <= '0;
            mem_rd_q      <= 1'b0;
            mem_we_q      <= 1'b0;
            cart_dout_q   <= '0;
            cart_valid_q  <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            is_rd_q       <= is_rd_d;
            wcnt_q        <= wcnt_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            ovf_q         <= ovf_d;
            dl_active_q   <= dl_active_i;
            pend_q        <= pend_d;
            pend_addr_q   <= pend_addr_d;
            cache_valid_q <= cache_valid_d;
            cache_addr_q  <= cache_addr_d;
            cache_data_q  <= cache_data_d;
            mem_addr_q    <= mem_addr_d;
            mem_din_q     <= mem_din_d;
            mem_rd_q      <= mem_rd_d;
            mem_we_q      <= mem_we_d;
            cart_dout_q   <= cart_dout_d;
            cart_valid_q  <= cart_valid_d;
            busy_q        <= busy_d;
        end
    end

    // Storage needs no reset: count/pointers define which entries are live.
    always_ff @(posedge clk_sys_i) begin
        if (w_push) begin
            fifo_addr_q[wr_ptr_q] <= dl_addr_i;
            fifo_data_q[wr_ptr_q] <= dl_data_i;
        end
    end

    assign dl_full_o     = w_full;
    assign dl_overflow_o = ovf_q;
    assign cart_dout_o   = cart_dout_q;
    assign cart_valid_o  = cart_valid_q;
    assign mem_addr_o    = mem_addr_q;
    assign mem_din_o     = mem_din_q;
    assign mem_rd_o      = mem_rd_q;
    assign mem_we_o      = mem_we_q;
    assign busy_o        = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_cart_mem_arbiter.sv
`default_nettype none
// ==========================================================================
// tb_cart_mem_arbiter: directed self-checking bench for cart_mem_arbiter.
// Revision: 1.0
// ==========================================================================
module tb_cart_mem_arbiter;

    localparam int ADDR_W     = 25;
    localparam int FIFO_DEPTH = 4;
    localparam int MEM_CYCLES = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              dl_active, dl_wr;
    logic [ADDR_W-1:0] dl_addr;
    logic [7:0]        dl_data;
    logic              dl_full, dl_overflow;
    logic              cart_rd;
    logic [ADDR_W-1:0] cart_addr;
    logic [7:0]        cart_dout;
    logic              cart_valid;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_din;
    logic              mem_rd, mem_we;
    logic [15:0]       mem_dout;
    logic              busy;

    always #5 clk = ~clk;

    cart_mem_arbiter #(
        .ADDR_W    (ADDR_W),
        .FIFO_DEPTH(FIFO_DEPTH),
        .MEM_CYCLES(MEM_CYCLES)
    ) u_dut (
        .clk_sys_i    (clk),
        .reset_i      (rst),
        .dl_active_i  (dl_active),
        .dl_wr_i      (dl_wr),
        .dl_addr_i    (dl_addr),
        .dl_data_i    (dl_data),
        .dl_full_o    (dl_full),
        .dl_overflow_o(dl_overflow),
        .cart_rd_i    (cart_rd),
        .cart_addr_i  (cart_addr),
        .cart_dout_o  (cart_dout),
        .cart_valid_o (cart_valid),
        .mem_addr_o   (mem_addr),
        .mem_din_o    (mem_din),
        .mem_rd_o     (mem_rd),
        .mem_we_o     (mem_we),
        .mem_dout_i   (mem_dout),
        .busy_o       (busy)
    );

    // SDRAM contents: 0x100 holds 0x00A5, everything else {EE, addr[7:0]^3C}.
    function automatic logic [15:0] sdram_model(input logic [ADDR_W-1:0] a);
        if (a == 25'h100) return 16'h00A5;
        return {8'hEE, a[7:0] ^ 8'h3C};
    endfunction
    assign mem_dout = sdram_model(mem_addr);

    int          r_n_chk = 0;
    int          r_n_err = 0;
    int          r_n_rd = 0, r_n_we = 0, r_n_valid = 0;
    logic [ADDR_W-1:0] r_last_rd_addr = '0;
    logic [15:0] r_we_din [$];
    logic        r_bad_cmd = 1'b0;
    logic        r_prev_cmd = 1'b0;
    logic        r_saw_full = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        r_n_chk++;
        if (got !== exp) begin
            r_n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mem_rd) begin
            r_n_rd++;
            r_last_rd_addr = mem_addr;
        end
        if (mem_we) begin
            r_n_we++;
            r_we_din.push_back(mem_din);
        end
        if (cart_valid) r_n_valid++;
        if (mem_rd && mem_we) r_bad_cmd = 1'b1;
        if ((mem_rd || mem_we) && r_prev_cmd) r_bad_cmd = 1'b1;
        r_prev_cmd = mem_rd | mem_we;
        if (dl_full) r_saw_full = 1'b1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input int max_cycles, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            if (cart_valid) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic pulse_rd(input logic [ADDR_W-1:0] a);
        cart_rd   = 1'b1;
        cart_addr = a;
        tick();
        cart_rd   = 1'b0;
    endtask

    initial begin
        bit ok;
        int rd0, v0;

        rst = 1'b1; dl_active = 1'b0; dl_wr = 1'b0; dl_addr = '0; dl_data = '0;
        cart_rd = 1'b0; cart_addr = '0;
        repeat (3) tick();
        check("rst_addr", 32'(mem_addr), 32'h0);
        check("rst_misc", {1'b0, mem_din, cart_dout, dl_full, dl_overflow, cart_valid,
                           mem_rd, mem_we, busy, 1'b0}, 32'h0);
        rst = 1'b0;
        repeat (2) tick();

        // Read miss latency: cycle 0 request, cycle 1 mem_rd, cycle 5 valid.
        pulse_rd(25'h100);
        check("miss_mem_rd_c1", 32'(mem_rd), 32'h1);
        check("miss_addr_c1", 32'(mem_addr), 32'h100);
        check("miss_busy_c1", 32'(busy), 32'h1);
        tick();
        check("miss_mem_rd_c2", 32'(mem_rd), 32'h0);
        tick(); tick();
        check("miss_valid_c4", 32'(cart_valid), 32'h0);
        check("miss_addr_held_c4", 32'(mem_addr), 32'h100);
        tick();
        check("miss_valid_c5", 32'(cart_valid), 32'h1);
        check("miss_dout_c5", 32'(cart_dout), 32'hA5);
        check("miss_busy_c5", 32'(busy), 32'h0);
        tick();
        check("miss_valid_c6", 32'(cart_valid), 32'h0);

        // Cache hit returns next cycle without touching SDRAM.
        rd0 = r_n_rd;
        pulse_rd(25'h100);
        check("hit_valid", 32'(cart_valid), 32'h1);
        check("hit_dout", 32'(cart_dout), 32'hA5);
        check("hit_mem_rd", 32'(mem_rd), 32'h0);
        repeat (5) tick();
        check("hit_no_sdram", 32'(r_n_rd - rd0), 32'h0);

        pulse_rd(25'h101);
        check("miss2_mem_rd", 32'(mem_rd), 32'h1);
        wait_valid(10, ok);
        check("miss2_valid", 32'(ok), 32'h1);
        check("miss2_dout", 32'(cart_dout), 32'h3D);
        check("miss2_one_rd", 32'(r_n_rd - rd0), 32'h1);
        tick();

        // Cache 0x003, then a download overwrites it.
        pulse_rd(25'h003);
        wait_valid(10, ok);
        check("pre_dl_dout", 32'(cart_dout), 32'h3F);
        tick();
        dl_active = 1'b1;
        tick();
        for (int i = 0; i < 6; i++) begin
            dl_wr   = 1'b1;
            dl_addr = ADDR_W'(i);
            dl_data = 8'(8'h10 + i);
            tick();
        end
        dl_wr = 1'b0;
        repeat (40) tick();
        check("dl_write_count", 32'(r_n_we), 32'd5);
        for (int i = 0; i < r_we_din.size() && i < 5; i++) begin
            check($sformatf("dl_din_%0d", i), 32'(r_we_din[i]), 32'(16'h1010 + 16'h0101 * i));
        end
        check("dl_saw_full", 32'(r_saw_full), 32'h1);
        check("dl_overflow", 32'(dl_overflow), 32'h1);
        check("dl_full_drained", 32'(dl_full), 32'h0);
        check("dl_busy_drained", 32'(busy), 32'h0);

        // Read held off while downloading; the written line must miss.
        rd0 = r_n_rd; v0 = r_n_valid;
        pulse_rd(25'h003);
        repeat (10) tick();
        check("dl_hold_no_rd", 32'(r_n_rd - rd0), 32'h0);
        check("dl_hold_no_valid", 32'(r_n_valid - v0), 32'h0);
        dl_active = 1'b0;
        wait_valid(20, ok);
        check("dl_release_valid", 32'(ok), 32'h1);
        check("dl_release_dout", 32'(cart_dout), 32'h3F);
        repeat (5) tick();
        check("dl_release_one_rd", 32'(r_n_rd - rd0), 32'h1);

        // Newest pending request wins; rising dl_active clears overflow.
        dl_active = 1'b1;
        tick(); tick();
        check("ovf_cleared", 32'(dl_overflow), 32'h0);
        rd0 = r_n_rd; v0 = r_n_valid;
        pulse_rd(25'h020);
        tick();
        pulse_rd(25'h030);
        repeat (3) tick();
        dl_active = 1'b0;
        wait_valid(20, ok);
        check("newest_valid", 32'(ok), 32'h1);
        check("newest_dout", 32'(cart_dout), 32'h0C);
        repeat (15) tick();
        check("newest_one_valid", 32'(r_n_valid - v0), 32'h1);
        check("newest_one_rd", 32'(r_n_rd - rd0), 32'h1);
        check("newest_addr", 32'(r_last_rd_addr), 32'h30);

        // Reset during WAIT aborts the read.
        v0 = r_n_valid;
        pulse_rd(25'h040);
        tick();
        rst = 1'b1;
        #1;
        check("abort_addr", 32'(mem_addr), 32'h0);
        check("abort_misc", {1'b0, mem_din, cart_dout, dl_full, dl_overflow, cart_valid,
                             mem_rd, mem_we, busy, 1'b0}, 32'h0);
        tick();
        rst = 1'b0;
        repeat (10) tick();
        check("abort_no_valid", 32'(r_n_valid - v0), 32'h0);
        check("abort_busy", 32'(busy), 32'h0);
        pulse_rd(25'h101);
        check("abort_cache_cleared", 32'(mem_rd), 32'h1);
        repeat (8) tick();

        check("cmd_spacing", 32'(r_bad_cmd), 32'h0);

        $display("Result: errors=%0d of %0d checks", r_n_err, r_n_chk);
        $finish;
    end

endmodule
`default_nettype wire
